branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side branch predictor that produces the predicted next PC (prePC) consumed by the PC register.
- A small direct-mapped BTB and 2-bit saturating-counter table is looked up combinationally with the current fetch PC.
- The table is trained by branch-resolution results from the execute stage.
- On a mispredict, the PC register takes the corrected PC directly from execute; this block only learns from the outcome.

Parameters:
- INDEX_W, 3, log2 of table entries (default 8 entries); index = pc[INDEX_W-1:0].
- TAG_W, 16-INDEX_W, tag width; tag = pc[15:INDEX_W]. Derived, not overridden.

Ports:
- clk  in  1  system clock; table writes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pc  in  16  current fetch PC (the PC register output).
- pred_pc  out  16  predicted next PC; drives the PC register's prePC input.
- pred_taken  out  1  1 = predicted-taken branch at pc.
- pred_hit  out  1  1 = valid BTB entry whose tag matches pc.
- upd_valid  in  1  execute stage resolved a branch/jump this cycle.
- upd_pc  in  16  PC of the resolved branch.
- upd_taken  in  1  actual direction.
- upd_target  in  16  actual target when taken.

Behaviour:
- Entry fields: valid (1), tag (TAG_W), target (16), cnt (2). Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (rst=0, async, takes effect immediately, including mid-update):
  - all valid=0, cnt=01, tag=0, target=0.
  - outputs become pred_hit=0, pred_taken=0, pred_pc=pc+1.
- Lookup (purely combinational, zero latency):
  - hit = valid[idx] && tag[idx]==pc[15:INDEX_W].
  - pred_taken = hit && cnt[idx][1].
  - pred_pc = pred_taken ? target[idx] : pc+1.
  - pc+1 is 16-bit modulo: 0xFFFF -> 0x0000.
- Update, on rising clk with upd_valid=1 (u = upd_pc index):
  - Hit on upd_pc, taken: cnt saturating +1 (11 stays 11); target <= upd_target.
  - Hit, not taken: cnt saturating -1 (00 stays 00); target unchanged.
  - Miss, taken: allocate/replace entry u: valid=1, tag=upd_pc tag, target=upd_target, cnt=10.
  - Miss, not taken: no write.
  - upd_valid=0: table holds.
- Simultaneous lookup and update of the same entry: lookup reflects pre-edge table contents. The new state is visible to lookup after the rising edge.
- Aliasing: different PCs with equal index and different tags replace each other on taken-miss. Otherwise they do not disturb each other.
- No stall/flush inputs. The PC register handles hold (PCKeep) and mispredict recovery; pred_pc simply tracks pc.
- The PC register samples pred_pc on falling clk. Table writes occur on the rising edge, so pred_pc is stable a half cycle before sampling.

Optional Feature:
- Macro BP_STATS_EN.
- Defined: adds outputs stat_branches[15:0] and stat_mispred[15:0], both reset to 0 by rst.
  - stat_branches increments on every upd_valid cycle.
  - stat_mispred increments when the pre-edge table prediction for upd_pc differs from actual. The pre-edge prediction is (hit && cnt[1]) for direction, plus target != upd_target when both predicted and actual are taken.
  - Both counters saturate at 0xFFFF.
- Undefined: these ports and registers do not exist. Prediction behaviour is identical either way.

Test Plan:
- Reset then pc=0x0010 -> pred_hit=0, pred_taken=0, pred_pc=0x0011; pc=0xFFFF -> pred_pc=0x0000.
- upd_valid, upd_pc=0x0012, taken, target=0x0040; next cycle pc=0x0012 -> pred_hit=1, pred_taken=1 (cnt=10), pred_pc=0x0040.
- Train 0x0012 twice more taken, then three not-taken. Counter path is 11, 11, 10, 01, 00. After the second not-taken, pc=0x0012 gives pred_taken=0 and pred_pc=0x0013.
- Taken update at 0x001A (same index as 0x0012, INDEX_W=3), target 0x0080 -> pc=0x0012 now pred_hit=0; pc=0x001A -> pred_pc=0x0080.
- Not-taken update at untrained 0x0025 -> no allocation; pc=0x0025 -> pred_hit=0. Then assert rst low mid-cycle during a taken update of 0x0012 -> table cleared immediately, no write occurs, and pc=0x0012 predicts 0x0013.
- BP_STATS_EN: 4 updates with 2 direction mispredicts and 1 target mismatch -> stat_branches=4, stat_mispred=3. Force 0xFFFF and update again -> both stay 0xFFFF.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit counters, combinational lookup, trained by execute.
// Optional BP_STATS_EN adds saturating branch/mispredict counters.
module branch_predictor #(
  parameter int unsigned INDEX_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  output logic [15:0] pred_pc,
  output logic        pred_taken,
  output logic        pred_hit,
  input  logic        upd_valid,
  input  logic [15:0] upd_pc,
  input  logic        upd_taken,
  input  logic [15:0] upd_target
`ifdef BP_STATS_EN
  ,
  output logic [15:0] stat_branches,
  output logic [15:0] stat_mispred
`endif
);

  localparam int unsigned TAG_W   = 16 - INDEX_W;
  localparam int unsigned ENTRIES = 2 ** INDEX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [15:0]      target;
    logic [1:0]       cnt;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: 16'h0000, cnt: 2'b01};

  entry_t table_q [ENTRIES];

  // Fetch-side lookup: sees pre-edge table contents
  logic [INDEX_W-1:0] lk_idx;
  entry_t             lk_entry;

  always_comb begin
    lk_idx     = pc[INDEX_W-1:0];
    lk_entry   = table_q[lk_idx];
    pred_hit   = lk_entry.valid && (lk_entry.tag == pc[15:INDEX_W]);
    pred_taken = pred_hit && lk_entry.cnt[1];
    pred_pc    = pred_taken ? lk_entry.target : pc + 16'd1;
  end

  // Training: compute the replacement entry and whether it is written
  logic [INDEX_W-1:0] u_idx;
  entry_t             u_entry;
  logic               u_hit;
  entry_t             u_next;
  logic               u_we;

  always_comb begin
    u_idx   = upd_pc[INDEX_W-1:0];
    u_entry = table_q[u_idx];
    u_hit   = u_entry.valid && (u_entry.tag == upd_pc[15:INDEX_W]);
    u_next  = u_entry;
    u_we    = 1'b0;
    if (upd_valid) begin
      if (u_hit) begin
        u_we = 1'b1;
        if (upd_taken) begin
          u_next.cnt    = (u_entry.cnt == 2'b11) ? 2'b11 : u_entry.cnt + 2'd1;
          u_next.target = upd_target;
        end else begin
          u_next.cnt = (u_entry.cnt == 2'b00) ? 2'b00 : u_entry.cnt - 2'd1;
        end
      end else if (upd_taken) begin
        u_we          = 1'b1;
        u_next.valid  = 1'b1;
        u_next.tag    = upd_pc[15:INDEX_W];
        u_next.target = upd_target;
        u_next.cnt    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        table_q[INDEX_W'(i)] <= RESET_ENTRY;
      end
    end else if (u_we) begin
      table_q[u_idx] <= u_next;
    end
  end

`ifdef BP_STATS_EN
  // Mispredict judged against the pre-edge prediction for upd_pc
  logic u_pred_taken;
  logic u_mispred;

  always_comb begin
    u_pred_taken = u_hit && u_entry.cnt[1];
    u_mispred    = (u_pred_taken != upd_taken) ||
                   (u_pred_taken && upd_taken && (u_entry.target != upd_target));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches <= 16'h0000;
      stat_mispred  <= 16'h0000;
    end else if (upd_valid) begin
      if (stat_branches != 16'hFFFF) stat_branches <= stat_branches + 16'd1;
      if (u_mispred && (stat_mispred != 16'hFFFF)) stat_mispred <= stat_mispred + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues expected lookups/stats, a negedge monitor compares.
// Define BP_STATS_EN to also exercise the statistics counters.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc = 16'h0000;
  logic [15:0] pred_pc;
  logic        pred_taken;
  logic        pred_hit;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_pc = 16'h0000;
  logic        upd_taken = 1'b0;
  logic [15:0] upd_target = 16'h0000;
`ifdef BP_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispred;
`endif

  branch_predictor #(.INDEX_W(3)) dut (
    .clk(clk), .rst(rst), .pc(pc),
    .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_hit(pred_hit),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
`ifdef BP_STATS_EN
    , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_stat;
    logic        hit;
    logic        taken;
    logic [15:0] ppc;
    logic [15:0] br;
    logic [15:0] mp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: pops one expectation per falling edge and compares
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (!e.is_stat) begin
        if ({pred_hit, pred_taken, pred_pc} !== {e.hit, e.taken, e.ppc}) begin
          n_fail++;
          $display("FAIL %s: pc=%h got hit=%b taken=%b pred_pc=%h, expected hit=%b taken=%b pred_pc=%h",
                   e.name, pc, pred_hit, pred_taken, pred_pc, e.hit, e.taken, e.ppc);
        end
      end
`ifdef BP_STATS_EN
      else if ({stat_branches, stat_mispred} !== {e.br, e.mp}) begin
        n_fail++;
        $display("FAIL %s: got branches=%h mispred=%h, expected branches=%h mispred=%h",
                 e.name, stat_branches, stat_mispred, e.br, e.mp);
      end
`endif
    end
  end

  task automatic push_look(input logic h, input logic t, input logic [15:0] pp, input string nm);
    exp_t e;
    e.is_stat = 1'b0; e.hit = h; e.taken = t; e.ppc = pp; e.br = '0; e.mp = '0; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic push_stat(input logic [15:0] br, input logic [15:0] mp, input string nm);
    exp_t e;
    e.is_stat = 1'b1; e.hit = 1'b0; e.taken = 1'b0; e.ppc = '0; e.br = br; e.mp = mp; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic look(input logic [15:0] p, input logic h, input logic t, input logic [15:0] pp,
                      input string nm);
    @(posedge clk); #1;
    pc = p;
    push_look(h, t, pp, nm);
    @(negedge clk); #1;
  endtask

  task automatic upd(input logic [15:0] p, input logic t, input logic [15:0] tg);
    @(posedge clk); #1;
    upd_valid = 1'b1; upd_pc = p; upd_taken = t; upd_target = tg;
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  initial begin
    // Reset values, observed while reset is held and after release
    look(16'h0010, 1'b0, 1'b0, 16'h0011, "reset_lookup");
`ifdef BP_STATS_EN
    @(posedge clk); #1; push_stat(16'h0000, 16'h0000, "stats_reset"); @(negedge clk); #1;
`endif
    @(negedge clk); rst = 1'b1;
    look(16'h0010, 1'b0, 1'b0, 16'h0011, "cold_lookup");
    look(16'hFFFF, 1'b0, 1'b0, 16'h0000, "pc_wrap");

    // Allocate on taken miss, cnt=10
    upd(16'h0012, 1'b1, 16'h0040);
    look(16'h0012, 1'b1, 1'b1, 16'h0040, "alloc_hit");
    look(16'h0013, 1'b0, 1'b0, 16'h0014, "neighbour_miss");

    // Counter path 11,11,10,01,00
    upd(16'h0012, 1'b1, 16'h0040);
    upd(16'h0012, 1'b1, 16'h0040);
    look(16'h0012, 1'b1, 1'b1, 16'h0040, "strong_taken");
    upd(16'h0012, 1'b0, 16'h0000);
    look(16'h0012, 1'b1, 1'b1, 16'h0040, "weak_taken");
    upd(16'h0012, 1'b0, 16'h0000);
    look(16'h0012, 1'b1, 1'b0, 16'h0013, "weak_not_taken");
    upd(16'h0012, 1'b0, 16'h0000);
    look(16'h0012, 1'b1, 1'b0, 16'h0013, "strong_not_taken");
    // From 00 one taken gives 01 (still NT); a second gives 10 with new target
    upd(16'h0012, 1'b1, 16'h0040);
    look(16'h0012, 1'b1, 1'b0, 16'h0013, "floor_saturated");
    upd(16'h0012, 1'b1, 16'h0050);
    look(16'h0012, 1'b1, 1'b1, 16'h0050, "target_retrain");

    // Aliasing replacement at index 2
    upd(16'h001A, 1'b1, 16'h0080);
    look(16'h0012, 1'b0, 1'b0, 16'h0013, "alias_evicted");
    look(16'h001A, 1'b1, 1'b1, 16'h0080, "alias_new");
    upd(16'h0033, 1'b1, 16'h0100);
    look(16'h001A, 1'b1, 1'b1, 16'h0080, "other_index_undisturbed");
    look(16'h0033, 1'b1, 1'b1, 16'h0100, "index3_alloc");

    // Not-taken miss never allocates
    upd(16'h0025, 1'b0, 16'h0000);
    look(16'h0025, 1'b0, 1'b0, 16'h0026, "nt_miss_no_alloc");

    // Hit not-taken keeps target, drops to weak NT
    upd(16'h001A, 1'b0, 16'h0000);
    look(16'h001A, 1'b1, 1'b0, 16'h001B, "hit_nt_down");
    upd(16'h001A, 1'b1, 16'h0080);
    look(16'h001A, 1'b1, 1'b1, 16'h0080, "hit_t_up");

    // Same-entry lookup during update shows pre-edge contents, new state after the edge
    @(posedge clk); #1;
    pc = 16'h0033;
    upd_valid = 1'b1; upd_pc = 16'h0033; upd_taken = 1'b1; upd_target = 16'h0200;
    push_look(1'b1, 1'b1, 16'h0100, "simul_pre_edge");
    @(negedge clk); #1;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    push_look(1'b1, 1'b1, 16'h0200, "simul_post_edge");
    @(negedge clk); #1;

    // Async reset mid-cycle during a taken update
    @(posedge clk); #1;
    pc = 16'h0012;
    upd_valid = 1'b1; upd_pc = 16'h0012; upd_taken = 1'b1; upd_target = 16'h0077;
    #2 rst = 1'b0;
    push_look(1'b0, 1'b0, 16'h0013, "reset_mid_cycle");
    @(posedge clk); #1;
    upd_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    look(16'h0012, 1'b0, 1'b0, 16'h0013, "reset_no_write");
    look(16'h001A, 1'b0, 1'b0, 16'h001B, "reset_cleared_1a");
    look(16'h0033, 1'b0, 1'b0, 16'h0034, "reset_cleared_33");

`ifdef BP_STATS_EN
    @(posedge clk); #1; push_stat(16'h0000, 16'h0000, "stats_after_reset"); @(negedge clk); #1;
    upd(16'h0040, 1'b1, 16'h0010);  // miss vs taken: direction mispredict
    upd(16'h0040, 1'b1, 16'h0011);  // predicted taken, wrong target
    upd(16'h0040, 1'b0, 16'h0000);  // predicted taken, actually not
    upd(16'h0048, 1'b0, 16'h0000);  // miss, not taken: correct
    @(posedge clk); #1; push_stat(16'd4, 16'd3, "stats_four"); @(negedge clk); #1;

    // Alternating aliasing taken updates all mispredict; run past saturation
    @(posedge clk); #1;
    upd_valid = 1'b1; upd_taken = 1'b1; upd_target = 16'h1000;
    for (int i = 0; i < 65540; i++) begin
      upd_pc = (i % 2 == 0) ? 16'h0040 : 16'h0048;
      @(posedge clk); #1;
    end
    upd_valid = 1'b0;
    push_stat(16'hFFFF, 16'hFFFF, "stats_saturated");
    @(negedge clk); #1;
    upd(16'h0040, 1'b1, 16'h2000);
    @(posedge clk); #1; push_stat(16'hFFFF, 16'hFFFF, "stats_hold_sat"); @(negedge clk); #1;
`endif

    repeat (2) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
